// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB widths, producer indices and slot entry type
package cdb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ROB_W   = 6;
  localparam int DATA_W  = 32;
  localparam logic [ROB_W-1:0] INVALID_TAG = 6'b100000;

  localparam int ADD_IDX = 0;
  localparam int MUL_IDX = 1;
  localparam int LD_IDX  = 2;
  localparam int BR_IDX  = 3;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - combinational round-robin finder of the first two occupied slots
module rr_pick import cdb_pkg::*; #(
  parameter int N  = NUM_REQ,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  occ,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  first_oh,
  output logic          first_found,
  output logic [N-1:0]  second_oh,
  output logic          second_found
);

  int            pos;
  logic [PW-1:0] idx;

  // Walk upward from ptr with wraparound; first hit is channel 1, second hit channel 2.
  always_comb begin
    first_oh     = '0;
    second_oh    = '0;
    first_found  = 1'b0;
    second_found = 1'b0;
    pos          = 0;
    idx          = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (occ[idx]) begin
        if (!first_found) begin
          first_oh[idx] = 1'b1;
          first_found   = 1'b1;
        end else if (!second_found) begin
          second_oh[idx] = 1'b1;
          second_found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - one-entry-per-producer CDB arbiter; CDB_DUAL_EN enables the second channel
module cdb_arbiter #(
  parameter int NUM_REQ = cdb_pkg::NUM_REQ,
  parameter int ROB_W   = cdb_pkg::ROB_W,
  parameter int DATA_W  = cdb_pkg::DATA_W,
  parameter logic [ROB_W-1:0] INVALID_TAG = cdb_pkg::INVALID_TAG
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_robNum,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] slot_valid;
  logic [ROB_W-1:0]   slot_tag  [NUM_REQ];
  logic [DATA_W-1:0]  slot_data [NUM_REQ];
  logic [PW-1:0]      ptr;

  logic [NUM_REQ-1:0] first_oh, second_oh, grant1, grant2, granted, accept;
  logic               first_found, second_found, found2;
  logic [ROB_W-1:0]   nxt_tag1, nxt_tag2;
  logic [DATA_W-1:0]  nxt_data1, nxt_data2;
  logic [PW-1:0]      last_idx, ptr_next;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .occ          (slot_valid),
    .ptr          (ptr),
    .first_oh     (first_oh),
    .first_found  (first_found),
    .second_oh    (second_oh),
    .second_found (second_found)
  );

  assign grant1 = first_oh;
`ifdef CDB_DUAL_EN
  assign grant2 = second_oh;
  assign found2 = second_found;
`else
  assign grant2 = '0;
  assign found2 = 1'b0;
  logic unused_second;
  assign unused_second = ^{second_oh, second_found};
`endif

  // A slot can take a new result if empty or leaving this cycle; flush blocks all accepts.
  assign granted   = grant1 | grant2;
  assign req_ready = flush ? '0 : (~slot_valid | granted);
  assign accept    = req_valid & req_ready;

  // Select granted entries for the channels and remember the highest-ranked grant for ptr.
  always_comb begin
    nxt_tag1  = INVALID_TAG;
    nxt_data1 = '0;
    nxt_tag2  = INVALID_TAG;
    nxt_data2 = '0;
    last_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant1[i]) begin
        nxt_tag1  = slot_tag[i];
        nxt_data1 = slot_data[i];
        last_idx  = PW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant2[i]) begin
        nxt_tag2  = slot_tag[i];
        nxt_data2 = slot_data[i];
        last_idx  = PW'(i);
      end
    end
  end

  assign ptr_next = (last_idx == PW'(NUM_REQ - 1)) ? '0 : last_idx + PW'(1);

  // Slot occupancy and round-robin pointer; a same-edge accept replaces a departing entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      ptr        <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_tag[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else if (flush) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          slot_valid[i] <= 1'b1;
          slot_tag[i]   <= req_robNum[i*ROB_W +: ROB_W];
          slot_data[i]  <= req_data[i*DATA_W +: DATA_W];
        end else if (granted[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (first_found) ptr <= ptr_next;
    end
  end

  // Registered CDB channels; idle on reset, flush or no grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_TAG;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_TAG;
      CDBdata2   <= '0;
    end else if (flush) begin
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_TAG;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_TAG;
      CDBdata2   <= '0;
    end else begin
      CDBiscast  <= first_found;
      CDBrobNum  <= nxt_tag1;
      CDBdata    <= nxt_data1;
      CDBiscast2 <= found2;
      CDBrobNum2 <= nxt_tag2;
      CDBdata2   <= nxt_data2;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter with a behavioural slot/queue model
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 4;

`ifdef CDB_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [23:0]  req_robNum = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic         CDBiscast, CDBiscast2;
  logic [5:0]   CDBrobNum, CDBrobNum2;
  logic [31:0]  CDBdata, CDBdata2;

  cdb_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_robNum (req_robNum),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .CDBiscast  (CDBiscast),
    .CDBrobNum  (CDBrobNum),
    .CDBdata    (CDBdata),
    .CDBiscast2 (CDBiscast2),
    .CDBrobNum2 (CDBrobNum2),
    .CDBdata2   (CDBdata2)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model state: per-producer held result, round-robin start, expected channel contents
  bit          m_valid [N];
  logic [5:0]  m_tag   [N];
  logic [31:0] m_data  [N];
  bit          m_ready [N];
  int          m_ptr;
  int          g1, g2;
  bit          e_cast1, e_cast2;
  logic [5:0]  e_tag1, e_tag2;
  logic [31:0] e_data1, e_data2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_idle();
    e_cast1 = 0; e_tag1 = INVALID_TAG; e_data1 = '0;
    e_cast2 = 0; e_tag2 = INVALID_TAG; e_data2 = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_ready[i] = 1;
    end
    m_ptr = 0;
    model_idle();
  endtask

  // who wins this cycle, and who may hand over a new result
  task automatic model_pick();
    g1 = -1; g2 = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (m_valid[i]) begin
        if (g1 < 0) g1 = i;
        else if (g2 < 0 && DUAL) g2 = i;
      end
    end
    for (int i = 0; i < N; i++)
      m_ready[i] = !flush && (!m_valid[i] || i == g1 || i == g2);
  endtask

  task automatic model_step();
    if (flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      model_idle();
    end else begin
      model_idle();
      if (g1 >= 0) begin
        e_cast1 = 1; e_tag1 = m_tag[g1]; e_data1 = m_data[g1]; m_valid[g1] = 0;
      end
      if (g2 >= 0) begin
        e_cast2 = 1; e_tag2 = m_tag[g2]; e_data2 = m_data[g2]; m_valid[g2] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && m_ready[i]) begin
          m_valid[i] = 1;
          m_tag[i]   = req_robNum[i*6 +: 6];
          m_data[i]  = req_data[i*32 +: 32];
        end
      end
      if (g2 >= 0) m_ptr = (g2 + 1) % N;
      else if (g1 >= 0) m_ptr = (g1 + 1) % N;
    end
  endtask

  task automatic compare();
    check("cdb1_cast", CDBiscast, e_cast1);
    check("cdb1_tag", CDBrobNum, e_tag1);
    check("cdb1_data", CDBdata, e_data1);
    check("cdb2_cast", CDBiscast2, e_cast2);
    check("cdb2_tag", CDBrobNum2, e_tag2);
    check("cdb2_data", CDBdata2, e_data2);
  endtask

  // one clock: check handshake, advance model, let DUT clock, check CDB outputs
  task automatic cycle();
    logic [3:0] exp_rdy;
    #1;
    model_pick();
    for (int i = 0; i < N; i++) exp_rdy[i] = m_ready[i];
    check("req_ready", req_ready, exp_rdy);
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  task automatic drive(input int i, input logic [5:0] tag, input logic [31:0] data);
    req_valid[i] = 1'b1;
    req_robNum[i*6 +: 6] = tag;
    req_data[i*32 +: 32] = data;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_cast1", CDBiscast, 0);
    check("rst_tag1", CDBrobNum, 6'b100000);
    check("rst_data1", CDBdata, 0);
    check("rst_cast2", CDBiscast2, 0);
    check("rst_tag2", CDBrobNum2, 6'b100000);
    check("rst_ready", req_ready, 4'hf);

    // single result from the add RS
    drive(ADD_IDX, 6'd5, 32'h1234);
    cycle();
    req_valid = '0;
    cycle();
    check("single_cast", CDBiscast, 1);
    check("single_tag", CDBrobNum, 6'd5);
    check("single_data", CDBdata, 32'h1234);
    check("single_cast2", CDBiscast2, 0);
    check("single_tag2", CDBrobNum2, 6'b100000);
    cycle();
    check("single_once", CDBiscast, 0);

    // all four producers at once from ptr = 0
    pulse_reset();
    for (int i = 0; i < N; i++) drive(i, 6'(i + 1), 32'hA0 + 32'(i));
    cycle();
    req_valid = '0;
    cycle();
    check("all4_e1_tag1", CDBrobNum, 6'd1);
`ifdef CDB_DUAL_EN
    check("all4_e1_tag2", CDBrobNum2, 6'd2);
    cycle();
    check("all4_e2_tag1", CDBrobNum, 6'd3);
    check("all4_e2_tag2", CDBrobNum2, 6'd4);
`else
    check("all4_e1_cast2", CDBiscast2, 0);
    cycle();
    check("all4_e2_tag1", CDBrobNum, 6'd2);
    cycle();
    check("all4_e3_tag1", CDBrobNum, 6'd3);
    cycle();
    check("all4_e4_tag1", CDBrobNum, 6'd4);
    check("all4_e4_data1", CDBdata, 32'hA3);
`endif
    check("all4_ptr", dut.ptr, 0);
    cycle();
    check("all4_drained", CDBiscast, 0);

    // producer 0 streams back-to-back
    for (int t = 0; t < 3; t++) begin
      drive(ADD_IDX, 6'(10 + t), 32'h100 + 32'(t));
      #1;
      check("stream_ready", req_ready[0], 1);
      cycle();
      if (t > 0) begin
        check("stream_cast", CDBiscast, 1);
        check("stream_tag", CDBrobNum, 6'(10 + t - 1));
      end
    end
    req_valid = '0;
    cycle();
    check("stream_last_tag", CDBrobNum, 6'd12);

    // flush with slots 1 and 3 occupied
    drive(MUL_IDX, 6'd21, 32'hBEEF);
    drive(BR_IDX, 6'd23, 32'hCAFE);
    cycle();
    req_valid = '0;
    flush = 1'b1;
    #1;
    check("flush_ready", req_ready, 4'h0);
    cycle();
    check("flush_cast1", CDBiscast, 0);
    check("flush_cast2", CDBiscast2, 0);
    flush = 1'b0;
    #1;
    check("flush_empty", req_ready, 4'hf);
    cycle();
    check("flush_no_cast", CDBiscast, 0);

    // reset while a strobe is up
    drive(LD_IDX, 6'd7, 32'h77);
    cycle();
    req_valid = '0;
    cycle();
    check("pre_rst_cast", CDBiscast, 1);
    reset = 1'b0;
    #1;
    check("arst_cast", CDBiscast, 0);
    check("arst_tag", CDBrobNum, 6'b100000);
    check("arst_data", CDBdata, 0);
    model_reset();
    reset = 1'b1;
    #1;
    check("arst_ready", req_ready, 4'hf);
    check("arst_ptr", dut.ptr, 0);

    // randomized traffic with flushes; producers hold while stalled
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !m_ready[i])) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          req_robNum[i*6 +: 6] = 6'($urandom);
          req_data[i*32 +: 32] = $urandom;
        end
      end
      flush = ($urandom_range(0, 99) < 4);
      cycle();
    end
    flush = 1'b0;
    req_valid = '0;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) among execution-side producers: add RS, multiply RS, load unit and branch unit. Each producer hands over one result (ROB tag + 32-bit value) through a valid/ready handshake. The arbiter holds it in a one-entry slot and drives it onto one of two registered CDB channels (`CDBiscast`/`CDBrobNum`/`CDBdata` and the `...2` set) using round-robin priority. All reservation stations and the ROB snoop these channels.

## Interface
Parameters:
- NUM_REQ, 4: number of producers; index 0 = addRS, 1 = mulRS, 2 = load, 3 = branch.
- ROB_W, 6: ROB tag width.
- DATA_W, 32: result width.
- INVALID_TAG, 6'b100000: tag driven when a channel is idle.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held results (mispredict).
- req_valid  in  NUM_REQ  producer i has a result.
- req_robNum  in  NUM_REQ*ROB_W  tag of producer i, at bits [i*ROB_W +: ROB_W].
- req_data  in  NUM_REQ*DATA_W  value of producer i.
- req_ready  out  NUM_REQ  slot i can accept this cycle (combinational).
- CDBiscast  out  1  channel-1 broadcast strobe.
- CDBrobNum  out  ROB_W  channel-1 tag.
- CDBdata  out  DATA_W  channel-1 value.
- CDBiscast2  out  1  channel-2 broadcast strobe.
- CDBrobNum2  out  ROB_W  channel-2 tag.
- CDBdata2  out  DATA_W  channel-2 value.

## Operation
- Each producer has one slot, holding a valid bit, a tag and data.
- Handshake: `req_ready[i]` = slot empty OR slot i is granted this cycle. When valid && ready at a clock edge, the slot is loaded.
- While valid is high and ready is low, the producer must hold valid, tag and data stable.
- Arbitration is combinational over occupied slots. Scanning starts at pointer `ptr` and proceeds upward modulo NUM_REQ:
  - the first occupied slot is granted channel 1;
  - the second occupied slot is granted channel 2.
- Granted slots clear at the edge. Their contents are registered onto the CDB outputs at the same edge.
- `ptr` update:
  - if anything was granted, `ptr` becomes (last granted index + 1) mod NUM_REQ;
  - otherwise `ptr` is unchanged.
- Idle channel: strobe 0, tag = INVALID_TAG, data = 0.
- Strobes are single-cycle pulses per result; a result is never broadcast twice.
- Fairness: with 2 channels and NUM_REQ=4, an occupied slot is granted within 2 cycles.
- Simultaneous grant and new accept on the same slot: the old entry leaves and the new entry loads. Per-producer throughput is therefore 1 per cycle.
- flush:
  - all slots clear;
  - the same-edge accept is ignored, and `req_ready` is forced to 0 while flush is high;
  - CDB outputs go idle at that edge;
  - `ptr` is kept.
- The arbiter does no tag-collision checking. The ROB guarantees unique in-flight tags.

## Timing
- Result accepted at edge k → earliest broadcast visible in cycle k+1 to k+2 (registered at edge k+1).
- Under contention, added latency is at most 1 extra cycle per blocking cycle, within the 2-cycle fairness bound.
- On reset assertion, asynchronously:
  - all strobes go to 0, tags to INVALID_TAG, data to 0;
  - all slots are emptied and `ptr` = 0;
  - `req_ready` reads all 1s once reset deasserts.
- Reset mid-broadcast kills the strobe immediately; the lost result is not replayed.

## Configuration
- `CDB_DUAL_EN` defined: both channels operate as above.
- Undefined:
  - only channel 1 is granted, at most one result per cycle;
  - `CDBiscast2` is tied 0, `CDBrobNum2` to INVALID_TAG, `CDBdata2` to 0;
  - `ptr` advances to (channel-1 grant index + 1) mod NUM_REQ;
  - fairness bound becomes NUM_REQ cycles.

## Structure
- Shared package `cdb_pkg`: ROB_W, DATA_W, INVALID_TAG, NUM_REQ, the producer index constants (ADD_IDX=0, MUL_IDX=1, LD_IDX=2, BR_IDX=3) and a `cdb_entry_t` struct (valid, tag, data).
- One sub-module, `rr_pick`:
  - purely combinational;
  - inputs: occupancy vector, `ptr`;
  - outputs: first/second grant one-hot plus their found flags.
- Slots, `ptr` and output registers live in `cdb_arbiter`.

## Test plan
- Single: slot 0 accepts tag 5, data 32'h1234 at edge 1 → `CDBiscast`=1, tag 5, data 32'h1234 for exactly one cycle after edge 2; channel 2 idle, tag 6'b100000.
- All four accepted together (tags 1–4), `ptr`=0 → edge A broadcasts tags 1 and 2 on channels 1/2, edge B broadcasts 3 and 4; `ptr`=0 afterwards.
- Producer 0 streams tags 10, 11, 12 in consecutive cycles with valid held → `req_ready[0]` stays 1 and tags appear on channel 1 in consecutive cycles.
- Slots 1 and 3 held, flush pulsed for one cycle → no strobe in the following cycles, `req_ready` = 0 during flush, both slots empty afterwards.
- Reset asserted (low) while `CDBiscast`=1 → strobe drops without a clock edge, tag reads 6'b100000, `ptr`=0 on release.
- `CDB_DUAL_EN` undefined, four results pending → one broadcast per cycle on channel 1 in order 0, 1, 2, 3; `CDBiscast2` never 1.
